// File: rtl/ledlines.sv
// LedLines board controller: start synchronizer, shared bit/frame sequencer and
// four WS2812-style NRZ encoders driving a moving single-pixel pattern.

module ledlines_lane #(
    parameter int          NUM_LEDS = 16,
    parameter int          PW       = 4,
    parameter int          CW       = 6,
    parameter int          T0H      = 20,
    parameter int          T1H      = 40,
    parameter logic [23:0] COLOR    = 24'h0,
    parameter int          OFS      = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send,
    input  logic [PW-1:0] pos,
    input  logic [PW-1:0] pix,
    input  logic [4:0]    bit_idx,
    input  logic [CW-1:0] cnt,
    output logic          sig
);
    logic [PW:0]   sum;
    logic [PW-1:0] lit;
    logic          bit_val;

    // OFS is already reduced mod NUM_LEDS, so one conditional subtract wraps.
    always_comb begin
        sum = {1'b0, pos} + (PW+1)'(OFS);
        if (sum >= (PW+1)'(NUM_LEDS))
            sum = sum - (PW+1)'(NUM_LEDS);
        lit     = sum[PW-1:0];
        bit_val = (pix == lit) && COLOR[bit_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= 1'b0;
        else
            sig <= send && (cnt < (bit_val ? CW'(T1H) : CW'(T0H)));
    end
endmodule

module ledlines_top #(
    parameter int          NUM_LEDS = 16,
    parameter int          TBIT     = 63,
    parameter int          T0H      = 20,
    parameter int          T1H      = 40,
    parameter int          TRESET   = 3000,
    parameter logic [7:0]  BRIGHT   = 8'h20
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic SW,
    output logic LED_SIG0,
    output logic LED_SIG1,
    output logic LED_SIG2,
    output logic LED_SIG3
);
    localparam int NUM_LANES = 4;
    localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CW = $clog2(TBIT + 1);
    localparam int LW = $clog2(TRESET + 1);
    // Per-lane {G,R,B}: red, green, blue, white.
    localparam logic [NUM_LANES-1:0][23:0] LANE_COLOR = {
        {BRIGHT, BRIGHT, BRIGHT},
        {8'h00,  8'h00,  BRIGHT},
        {BRIGHT, 8'h00,  8'h00 },
        {8'h00,  BRIGHT, 8'h00 }
    };

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t               state;
    logic [1:0]           sw_sync;
    logic                 started;
    logic [CW-1:0]        cnt;
    logic [4:0]           bit_idx;
    logic [PW-1:0]        pix;
    logic [PW-1:0]        pos;
    logic [LW-1:0]        lat;
    logic [NUM_LANES-1:0] sig;

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            state   <= IDLE;
            sw_sync <= '0;
            started <= 1'b0;
            cnt     <= '0;
            bit_idx <= '0;
            pix     <= '0;
            pos     <= '0;
            lat     <= '0;
        end else begin
            sw_sync <= {sw_sync[0], SW};
            if (sw_sync[1])
                started <= 1'b1;
            case (state)
                IDLE: if (started) begin
                    state   <= SEND;
                    cnt     <= '0;
                    pix     <= '0;
                    bit_idx <= 5'd23;
                end
                SEND: if (cnt == CW'(TBIT - 1)) begin
                    cnt <= '0;
                    if (bit_idx == 5'd0) begin
                        bit_idx <= 5'd23;
                        if (pix == PW'(NUM_LEDS - 1)) begin
                            pix   <= '0;
                            lat   <= '0;
                            state <= LATCH;
                        end else begin
                            pix <= pix + 1'b1;
                        end
                    end else begin
                        bit_idx <= bit_idx - 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                LATCH: if (lat == LW'(TRESET - 1)) begin
                    state <= SEND;
                    pos   <= (pos == PW'(NUM_LEDS - 1)) ? '0 : pos + 1'b1;
                end else begin
                    lat <= lat + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        ledlines_lane #(
            .NUM_LEDS (NUM_LEDS),
            .PW       (PW),
            .CW       (CW),
            .T0H      (T0H),
            .T1H      (T1H),
            .COLOR    (LANE_COLOR[k]),
            .OFS      ((4 * k) % NUM_LEDS)
        ) u_lane (
            .clk     (CLK),
            .rst     (RST_N),
            .send    (state == SEND),
            .pos     (pos),
            .pix     (pix),
            .bit_idx (bit_idx),
            .cnt     (cnt),
            .sig     (sig[k])
        );
    end

    assign LED_SIG0 = sig[0];
    assign LED_SIG1 = sig[1];
    assign LED_SIG2 = sig[2];
    assign LED_SIG3 = sig[3];
endmodule

// File: tb/tb_ledlines_top.sv
// Directed bench: decodes the four NRZ lines bit by bit and compares each frame
// against the moving-pixel pattern; short timing parameters keep 17 frames cheap.

module tb_ledlines_top;
    localparam int NL     = 16;
    localparam int TBIT   = 8;
    localparam int T0H    = 2;
    localparam int T1H    = 5;
    localparam int TRESET = 40;
    localparam int NBITS  = NL * 24;

    logic CLK, RST_N, SW;
    logic LED_SIG0, LED_SIG1, LED_SIG2, LED_SIG3;
    logic [3:0] led;
    assign led = {LED_SIG3, LED_SIG2, LED_SIG1, LED_SIG0};

    int n_tests = 0;
    int n_fail  = 0;
    logic [NBITS-1:0] cap [4];

    ledlines_top #(
        .NUM_LEDS (NL),
        .TBIT     (TBIT),
        .T0H      (T0H),
        .T1H      (T1H),
        .TRESET   (TRESET),
        .BRIGHT   (8'h20)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SW       (SW),
        .LED_SIG0 (LED_SIG0),
        .LED_SIG1 (LED_SIG1),
        .LED_SIG2 (LED_SIG2),
        .LED_SIG3 (LED_SIG3)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [NBITS-1:0] got, input logic [NBITS-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NBITS-1:0] model(input int line, input int pos);
        logic [NBITS-1:0] m;
        logic [23:0] col;
        int lit;
        case (line)
            0:       col = 24'h002000;
            1:       col = 24'h200000;
            2:       col = 24'h000020;
            default: col = 24'h202020;
        endcase
        lit = (pos + 4 * line) % NL;
        m = '0;
        for (int p = 0; p < NL; p++)
            m[NBITS-1-24*p -: 24] = (p == lit) ? col : 24'h0;
        return m;
    endfunction

    // Starts with the current sample as cycle 0 of bit 0.
    task automatic capture(output logic [3:0] first, output int bad);
        int  h  [4];
        bit  lo [4];
        bad   = 0;
        first = '0;
        for (int b = 0; b < NBITS; b++) begin
            for (int l = 0; l < 4; l++) begin h[l] = 0; lo[l] = 0; end
            for (int c = 0; c < TBIT; c++) begin
                if (b != 0 || c != 0) @(negedge CLK);
                if (b == 0 && c == 0) first = led;
                for (int l = 0; l < 4; l++) begin
                    if (led[l]) begin
                        if (lo[l]) bad++;
                        h[l]++;
                    end else begin
                        lo[l] = 1;
                    end
                end
            end
            for (int l = 0; l < 4; l++) begin
                cap[l][NBITS-1-b] = (h[l] == T1H);
                if (h[l] != T1H && h[l] != T0H) bad++;
            end
        end
    endtask

    // Leaves the bench on the first high sample after the latch gap.
    task automatic measure_latch(output int low);
        low = 0;
        @(negedge CLK);
        while (led == 4'h0 && low < TRESET + 10) begin
            low++;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [3:0] first;
        int bad, low, hi;

        RST_N = 1'b1;
        SW    = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_out", led, 4'h0);
        @(posedge CLK); #1 RST_N = 1'b0;

        hi = 0;
        repeat (10000) begin @(negedge CLK); if (led != 4'h0) hi++; end
        check("idle_sw0", hi, 0);

        @(posedge CLK); #1 SW = 1'b1;
        @(posedge CLK);                  // edge k: SW first sampled high
        repeat (3) @(posedge CLK);       // edge k+3
        @(negedge CLK);
        check("pre_start_k3", led, 4'h0);
        @(negedge CLK);                  // after edge k+4

        for (int f = 0; f <= 16; f++) begin
            if (f > 0) begin
                measure_latch(low);
                check($sformatf("latch_len_f%0d", f), low, TRESET);
            end
            capture(first, bad);
            if (f == 0) check("start_rise_k4", first, 4'hf);
            check($sformatf("pulse_shape_f%0d", f), bad, 0);
            for (int l = 0; l < 4; l++)
                check($sformatf("frame%0d_line%0d", f, l), cap[l], model(l, f % NL));
        end

        measure_latch(low);
        check("latch_len_f17", low, TRESET);
        check("f17_bit0_high", led, 4'hf);
        #2 RST_N = 1'b1;
        #1 check("async_reset_low", led, 4'h0);
        SW = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b0;
        hi = 0;
        repeat (200) begin @(negedge CLK); if (led != 4'h0) hi++; end
        check("no_restart_after_rst", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
